cond_eval_stage: RTL and testbench
==================================

// Module: cond_eval_stage
// PURPOSE
//   Parametrised successor to the single-lane NZCV condition checker. Owns the status
//   register and evaluates ARM-style 4-bit condition codes for LANES instructions per
//   transfer, against current or bypassed flags. Results go into a registered
//   valid/ready stage between ID and EXE, with flush and a saturating annul counter.
//   Sits beside the ID/EXE pipeline register; EXE drives the flag write-back.
// PARAMETERS
//   LANES      2   condition codes evaluated per accepted transfer (1..4)
//   FLAG_BYPASS 1  1: a same-cycle sr_we/sr_in is forwarded to evaluation; 0: only sr_q is used
//   CNT_W      16  width of the annulled-lane counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   sr_we      in   1          EXE S-bit: load sr_in into the status register this edge
//   sr_in      in   4          new flags {Z,C,N,V}
//   flush      in   1          kill the held result (branch taken / hazard flush)
//   in_valid   in   1          cond_in is valid
//   in_ready   out  1          stage can accept this cycle
//   cond_in    in   4*LANES    lane i condition at [4i+3:4i]
//   out_valid  out  1          cond_pass holds a live result
//   out_ready  in   1          consumer takes the result this cycle
//   cond_pass  out  LANES      bit i = 1: lane i executes
//   sr_out     out  4          architectural status register {Z,C,N,V}
//   annul_cnt  out  CNT_W      count of evaluated lanes with pass = 0, saturating
// BEHAVIOUR
//   Reset (async): sr_q=4'b0000, out_valid=0, cond_pass=0, annul_cnt=0.
//   Status register: sr_q <= sr_in when sr_we, otherwise hold. sr_out = sr_q.
//   Evaluation flags: F = (FLAG_BYPASS && sr_we) ? sr_in : sr_q. This is combinational.
//   Condition table ({Z,C,N,V} order; the ARM-correct forms are the decided semantics):
//     0000 EQ Z | 0001 NE !Z | 0010 CS C | 0011 CC !C | 0100 MI N | 0101 PL !N
//     0110 VS V | 0111 VC !V | 1000 HI C&!Z | 1001 LS !C|Z | 1010 GE N==V
//     1011 LT N!=V | 1100 GT !Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1 | 1111 NV 0
//   Handshake:
//     - in_ready = !out_valid | out_ready.
//     - accept = in_valid & in_ready & !flush.
//     - On accept: cond_pass <= eval(cond_in, F) and out_valid <= 1. Latency is 1 cycle.
//     - Otherwise, if out_ready or flush, then out_valid <= 0.
//     - A held result does not re-evaluate when flags change later; it is frozen at acceptance.
//   Flush has priority over accept and over hold. The next cycle gives out_valid=0, and
//   the offered input is dropped. Flush does not affect sr_q.
//   Simultaneous sr_we and accept: with FLAG_BYPASS=1, evaluation uses sr_in. With
//   FLAG_BYPASS=0, evaluation uses the old sr_q.
//   Annul count: on accept, annul_cnt += number of 0 bits in the new cond_pass.
//   The count saturates at 2^CNT_W-1 and does not wrap.
//   Back-pressure: out_valid=1 & out_ready=0 holds cond_pass stable and forces in_ready=0.
//   Reset mid-transfer: the in-flight result is lost, and flags clear to 0
//   (EQ fails, NE passes).
// STRUCTURE
//   Shared package cond_pkg:
//     - localparams COND_EQ..COND_NV
//     - flag bit indices Z_IDX=3, C_IDX=2, N_IDX=1, V_IDX=0
//   Sub-module cond_lane_eval: pure combinational, (cond[3:0], flags[3:0]) -> pass.
//   It is instantiated LANES times by a generate loop.
//   Top level holds sr_q, the output register, the handshake and the popcount/saturating counter.
// TESTING
//   1. Table sweep: for all 16 conds x 16 flag values with LANES=1, compare pass to the
//      table. Check LS at Z=1,C=1 -> 1 and LE at Z=1,N=V -> 1.
//   2. Bypass: sr_q=0000, sr_we=1, sr_in=1000, cond=EQ in the same cycle.
//      FLAG_BYPASS=1 -> pass=1. FLAG_BYPASS=0 -> pass=0. Next cycle sr_out=1000.
//   3. Back-pressure: accept, then out_ready=0 for 3 cycles while sr changes.
//      Require in_ready=0, and cond_pass/out_valid stable and unchanged.
//   4. Flush: flush=1 with in_valid=1 while holding a result -> next cycle out_valid=0,
//      annul_cnt unchanged, sr_q unchanged.
//   5. Counter: CNT_W=2, LANES=2, four accepts of {NV,NV}. annul_cnt goes 2,3,3,3.
//   6. Async reset: assert rst mid-transfer between edges.
//      Outputs zero immediately, and on release in_ready=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code encodings and status-flag bit positions for the
// condition evaluation stage.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flags are packed {Z,C,N,V}
    localparam int Z_IDX = 3;
    localparam int C_IDX = 2;
    localparam int N_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cond_lane_eval.sv
// Single-lane combinational condition check: one 4-bit ARM condition code
// against a {Z,C,N,V} flag set.
module cond_lane_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign n = flags[N_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_eval_stage.sv
// Status register plus multi-lane condition evaluation feeding a registered
// valid/ready stage between ID and EXE, with flush and a saturating annul count.
module cond_eval_stage
    import cond_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int FLAG_BYPASS = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sr_we,
    input  logic [3:0]           sr_in,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   cond_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     cond_pass,
    output logic [3:0]           sr_out,
    output logic [CNT_W-1:0]     annul_cnt
);

    localparam int ZW = $clog2(LANES + 1);
    localparam int SW = CNT_W + ZW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       sr_q;
    logic [3:0]       flags;
    logic [LANES-1:0] pass_d;
    logic             accept;
    logic [ZW-1:0]    zeros;
    logic [SW-1:0]    cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // A same-cycle write-back from EXE is visible to the instruction being accepted
    assign flags = ((FLAG_BYPASS != 0) && sr_we) ? sr_in : sr_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_lane_eval u_lane (
            .cond  (cond_in[4*i +: 4]),
            .flags (flags),
            .pass  (pass_d[i])
        );
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign sr_out   = sr_q;

    always_comb begin
        zeros = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!pass_d[i]) zeros = zeros + ZW'(1);
        end
    end

    always_comb begin
        cnt_sum  = SW'(annul_cnt) + SW'(zeros);
        cnt_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= 4'b0000;
            out_valid <= 1'b0;
            cond_pass <= '0;
            annul_cnt <= '0;
        end else begin
            if (sr_we) sr_q <= sr_in;
            if (accept) begin
                out_valid <= 1'b1;
                cond_pass <= pass_d;
                annul_cnt <= cnt_next;
            end else if (out_ready || flush) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cond_eval_stage.sv
// Self-checking bench for cond_eval_stage: three configurations share stimulus.
module tb_cond_eval_stage;
    import cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sr_we, flush, in_valid, out_ready;
    logic [3:0] sr_in;
    logic [3:0] cond1;
    logic [7:0] cond2;

    // u1: LANES=1 bypass on; u0: LANES=1 bypass off; u2: LANES=2, CNT_W=2
    logic        u1_in_ready, u1_out_valid;
    logic [0:0]  u1_pass;
    logic [3:0]  u1_sr;
    logic [15:0] u1_cnt;
    logic        u0_in_ready, u0_out_valid;
    logic [0:0]  u0_pass;
    logic [3:0]  u0_sr;
    logic [15:0] u0_cnt;
    logic        u2_in_ready, u2_out_valid;
    logic [1:0]  u2_pass;
    logic [3:0]  u2_sr;
    logic [1:0]  u2_cnt;

    int checks = 0;
    int failures = 0;

    logic q1[$];
    logic q0[$];
    logic [1:0] q2[$];

    always #5 clk = ~clk;

    cond_eval_stage #(.LANES(1), .FLAG_BYPASS(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .flush(flush),
        .in_valid(in_valid), .in_ready(u1_in_ready), .cond_in(cond1),
        .out_valid(u1_out_valid), .out_ready(out_ready), .cond_pass(u1_pass),
        .sr_out(u1_sr), .annul_cnt(u1_cnt));

    cond_eval_stage #(.LANES(1), .FLAG_BYPASS(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .flush(flush),
        .in_valid(in_valid), .in_ready(u0_in_ready), .cond_in(cond1),
        .out_valid(u0_out_valid), .out_ready(out_ready), .cond_pass(u0_pass),
        .sr_out(u0_sr), .annul_cnt(u0_cnt));

    cond_eval_stage #(.LANES(2), .FLAG_BYPASS(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .flush(flush),
        .in_valid(in_valid), .in_ready(u2_in_ready), .cond_in(cond2),
        .out_valid(u2_out_valid), .out_ready(out_ready), .cond_pass(u2_pass),
        .sr_out(u2_sr), .annul_cnt(u2_cnt));

    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v;
        z = f[3]; cy = f[2]; n = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cy;
            4'd3:  return ~cy;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cy & ~z;
            4'd9:  return ~cy | z;
            4'd10: return ~(n ^ v);
            4'd11: return n ^ v;
            4'd12: return ~z & ~(n ^ v);
            4'd13: return z | (n ^ v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        sr_we = 0; sr_in = 4'h0; flush = 0; in_valid = 0; out_ready = 1;
        cond1 = 4'h0; cond2 = 8'h00;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        q1.delete(); q0.delete(); q2.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        checks++;
        if ({u2_out_valid, u2_pass, u2_sr, u2_cnt} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state u2 got v=%b p=%b sr=%b cnt=%0d want all zero",
                     u2_out_valid, u2_pass, u2_sr, u2_cnt);
        end
        checks++;
        if ({u1_out_valid, u1_pass, u1_sr, u1_cnt} !== 22'b0 || u1_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state u1 got v=%b p=%b sr=%b cnt=%0d rdy=%b want zeros rdy=1",
                     u1_out_valid, u1_pass, u1_sr, u1_cnt, u1_in_ready);
        end
    endtask

    // Streams every condition back to back under every flag value
    task automatic test_table_sweep();
        logic [3:0] msr;
        int unsigned m_annul;
        logic exp;
        reset_dut();
        msr = 4'h0;
        m_annul = 0;
        for (int step = 0; step <= 16 * 17; step++) begin
            @(negedge clk);
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                checks++;
                if (u1_out_valid !== 1'b1 || u1_pass[0] !== exp) begin
                    failures++;
                    $display("FAIL sweep_u1 step=%0d got v=%b p=%b want v=1 p=%b",
                             step, u1_out_valid, u1_pass, exp);
                end
            end
            if (q0.size() > 0) begin
                exp = q0.pop_front();
                checks++;
                if (u0_out_valid !== 1'b1 || u0_pass[0] !== exp) begin
                    failures++;
                    $display("FAIL sweep_u0 step=%0d got v=%b p=%b want v=1 p=%b",
                             step, u0_out_valid, u0_pass, exp);
                end
            end
            idle_inputs();
            if (step < 16 * 17) begin
                if (step % 17 == 0) begin
                    sr_we = 1;
                    sr_in = 4'(step / 17);
                    msr   = sr_in;
                end else begin
                    cond1    = 4'(step % 17 - 1);
                    cond2    = {cond1, cond1};
                    in_valid = 1;
                    exp = ref_eval(cond1, msr);
                    q1.push_back(exp);
                    q0.push_back(exp);
                    if (!exp) m_annul++;
                end
            end
        end
        checks++;
        if (u1_cnt !== 16'(m_annul)) begin
            failures++;
            $display("FAIL sweep_annul got %0d want %0d", u1_cnt, m_annul);
        end
    endtask

    task automatic test_ls_le();
        reset_dut();
        sr_we = 1; sr_in = 4'b1100;
        @(negedge clk);
        idle_inputs(); cond1 = COND_LS; in_valid = 1;
        @(negedge clk);
        checks++;
        if (u1_pass !== 1'b1 || u0_pass !== 1'b1) begin
            failures++;
            $display("FAIL ls_z1c1 got u1=%b u0=%b want 1", u1_pass, u0_pass);
        end
        idle_inputs(); sr_we = 1; sr_in = 4'b1000;
        @(negedge clk);
        idle_inputs(); cond1 = COND_LE; in_valid = 1;
        @(negedge clk);
        checks++;
        if (u1_pass !== 1'b1 || u0_pass !== 1'b1) begin
            failures++;
            $display("FAIL le_z1_neqv got u1=%b u0=%b want 1", u1_pass, u0_pass);
        end
    endtask

    task automatic test_bypass();
        reset_dut();
        sr_we = 1; sr_in = 4'b1000; cond1 = COND_EQ; in_valid = 1;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (u1_out_valid !== 1'b1 || u1_pass !== 1'b1) begin
            failures++;
            $display("FAIL bypass_on got v=%b p=%b want v=1 p=1", u1_out_valid, u1_pass);
        end
        checks++;
        if (u0_out_valid !== 1'b1 || u0_pass !== 1'b0) begin
            failures++;
            $display("FAIL bypass_off got v=%b p=%b want v=1 p=0", u0_out_valid, u0_pass);
        end
        checks++;
        if (u1_sr !== 4'b1000 || u0_sr !== 4'b1000) begin
            failures++;
            $display("FAIL bypass_sr got u1=%b u0=%b want 1000", u1_sr, u0_sr);
        end
    endtask

    task automatic test_backpressure_flush();
        logic [3:0] msr;
        reset_dut();
        cond2 = {COND_EQ, COND_NE}; in_valid = 1;
        @(negedge clk);
        checks++;
        if (u2_out_valid !== 1'b1 || u2_pass !== 2'b01 || u2_cnt !== 2'd1) begin
            failures++;
            $display("FAIL bp_accept got v=%b p=%b cnt=%0d want v=1 p=01 cnt=1",
                     u2_out_valid, u2_pass, u2_cnt);
        end
        out_ready = 0; cond2 = {COND_NV, COND_NV}; in_valid = 1;
        msr = 4'h0;
        for (int k = 0; k < 3; k++) begin
            sr_we = 1; sr_in = 4'(4'b1111 - k); msr = sr_in;
            #1;
            checks++;
            if (u2_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got %b want 0", k, u2_in_ready);
            end
            @(negedge clk);
            checks++;
            if (u2_out_valid !== 1'b1 || u2_pass !== 2'b01 || u2_cnt !== 2'd1) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b p=%b cnt=%0d want v=1 p=01 cnt=1",
                         k, u2_out_valid, u2_pass, u2_cnt);
            end
        end
        sr_we = 0; flush = 1; in_valid = 1; out_ready = 0;
        @(negedge clk);
        idle_inputs(); out_ready = 0;
        #1;
        checks++;
        if (u2_out_valid !== 1'b0 || u2_cnt !== 2'd1 || u2_sr !== msr) begin
            failures++;
            $display("FAIL flush got v=%b cnt=%0d sr=%b want v=0 cnt=1 sr=%b",
                     u2_out_valid, u2_cnt, u2_sr, msr);
        end
        checks++;
        if (u2_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready got %b want 1", u2_in_ready);
        end
    endtask

    task automatic test_counter_saturate();
        logic [1:0] exp_cnt [4];
        exp_cnt = '{2'd2, 2'd3, 2'd3, 2'd3};
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cond2 = {COND_NV, COND_NV}; in_valid = 1; out_ready = 1;
            @(negedge clk);
            checks++;
            if (u2_cnt !== exp_cnt[k] || u2_pass !== 2'b00 || u2_out_valid !== 1'b1) begin
                failures++;
                $display("FAIL annul_sat k=%0d got cnt=%0d p=%b v=%b want cnt=%0d p=00 v=1",
                         k, u2_cnt, u2_pass, u2_out_valid, exp_cnt[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        cond2 = {COND_NV, COND_AL}; in_valid = 1; sr_we = 1; sr_in = 4'hF; out_ready = 0;
        @(posedge clk);
        #2;
        checks++;
        if (u2_out_valid !== 1'b1 || u2_pass !== 2'b01 || u2_cnt !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset got v=%b p=%b cnt=%0d want v=1 p=01 cnt=1",
                     u2_out_valid, u2_pass, u2_cnt);
        end
        rst = 1;
        #1;
        checks++;
        if ({u2_out_valid, u2_pass, u2_sr, u2_cnt} !== 9'b0) begin
            failures++;
            $display("FAIL async_reset got v=%b p=%b sr=%b cnt=%0d want zeros",
                     u2_out_valid, u2_pass, u2_sr, u2_cnt);
        end
        @(negedge clk);
        idle_inputs(); out_ready = 0;
        rst = 0;
        #1;
        checks++;
        if (u2_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got %b want 1", u2_in_ready);
        end
        @(negedge clk);
        idle_inputs(); cond1 = COND_EQ; in_valid = 1;
        @(negedge clk);
        idle_inputs(); cond1 = COND_NE; in_valid = 1;
        checks++;
        if (u1_pass !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_eq got %b want 0", u1_pass);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (u1_pass !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ne got %b want 1", u1_pass);
        end
    endtask

    // Random valid/ready/flush/flag traffic on the 2-lane instance
    task automatic test_back_to_back();
        logic [3:0] msr, f;
        logic [1:0] exp;
        logic acc;
        reset_dut();
        msr = 4'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            checks++;
            if (q2.size() > 0) begin
                if (u2_out_valid !== 1'b1 || u2_pass !== q2[0]) begin
                    failures++;
                    $display("FAIL b2b_out cyc=%0d got v=%b p=%b want v=1 p=%b",
                             cyc, u2_out_valid, u2_pass, q2[0]);
                end
            end else if (u2_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_out cyc=%0d got v=%b want v=0", cyc, u2_out_valid);
            end
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(9) == 0);
            sr_we     = ($urandom_range(3) == 0);
            sr_in     = 4'($urandom_range(15));
            cond2     = 8'($urandom_range(255));
            #1;
            checks++;
            if (u2_in_ready !== ((q2.size() == 0) || out_ready)) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got %b want %b",
                         cyc, u2_in_ready, (q2.size() == 0) || out_ready);
            end
            f   = sr_we ? sr_in : msr;
            acc = in_valid && ((q2.size() == 0) || out_ready) && !flush;
            if ((out_ready || flush) && q2.size() > 0) void'(q2.pop_front());
            if (acc) begin
                exp = {ref_eval(cond2[7:4], f), ref_eval(cond2[3:0], f)};
                q2.push_back(exp);
            end
            if (sr_we) msr = sr_in;
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (u2_sr !== msr) begin
            failures++;
            $display("FAIL b2b_sr got %b want %b", u2_sr, msr);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_table_sweep();
        test_ls_le();
        test_bypass();
        test_backpressure_flush();
        test_counter_saturate();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
